narrow_array_multiplier: RTL and testbench



---
 rtl/narrow_array_multiplier_pkg.sv | 21 ++
 rtl/narrow_array_multiplier_if.sv | 12 +
 rtl/narrow_array_multiplier_cell.sv | 15 +
 rtl/narrow_array_multiplier.sv | 112 +++++++++++
 tb/tb_narrow_array_multiplier.sv | 106 ++++++++++
 5 files changed

// File: rtl/narrow_array_multiplier_pkg.sv
// Shared sizing helpers and the narrow-operand predicate for the array multiplier.
package narrow_array_multiplier_pkg;

    localparam int MAX_W = 64;

    function automatic int half_of(input int width);
        return width / 2;
    endfunction

    function automatic int pwidth_of(input int width);
        return 2 * width;
    endfunction

    // Operands arrive zero-extended to MAX_W; narrow means nothing set above the lower half.
    function automatic logic is_narrow(input logic [MAX_W-1:0] a,
                                       input logic [MAX_W-1:0] b,
                                       input int width);
        return ((a | b) >> half_of(width)) == '0;
    endfunction

endpackage

// File: rtl/narrow_array_multiplier_if.sv
// Operand/result bundle for the narrow array multiplier.
interface narrow_array_multiplier_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] product;
    logic               narrow;

    modport master (output a, output b, input product, input narrow);
    modport slave  (input a, input b, output product, output narrow);
endinterface

// File: rtl/narrow_array_multiplier_cell.sv
// One array cell: partial-product AND feeding a full adder.
module narrow_array_mult_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic sum_in,
    input  logic carry_in,
    output logic sum_out,
    output logic carry_out
);
    logic pp;

    assign pp        = a_bit & b_bit;
    assign sum_out   = pp ^ sum_in ^ carry_in;
    assign carry_out = (pp & sum_in) | (pp & carry_in) | (sum_in & carry_in);
endmodule

// File: rtl/narrow_array_multiplier.sv
// Carry-save array multiplier with a registered product; narrow operands are
// served by the lower-corner sub-array while the upper rows/columns are gated to zero.
module narrow_array_multiplier
    import narrow_array_multiplier_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    narrow_array_multiplier_if.slave  bus
);
    localparam int HALF   = half_of(WIDTH);
    localparam int PWIDTH = pwidth_of(WIDTH);

    logic               narrow_d;
    logic [WIDTH-1:0]   a_g, b_g;
    logic [WIDTH-1:0]   col0_sum;
    logic [WIDTH-1:0]   last_sum, last_carry;
    logic [HALF-1:0]    corner_sum, corner_carry;
    logic [PWIDTH-1:0]  full_prod;
    logic [2*HALF-1:0]  corner_prod;
    logic [PWIDTH-1:0]  product_q;
    logic               narrow_q;

    always_comb begin
        narrow_d = is_narrow(MAX_W'(bus.a), MAX_W'(bus.b), WIDTH);
        a_g      = bus.a;
        b_g      = bus.b;
        if (narrow_d) begin
            a_g[WIDTH-1:HALF] = '0;
            b_g[WIDTH-1:HALF] = '0;
        end
    end

    // Row i handles b[i]; cell (i,j) has weight i+j, fed by sum from (i-1,j+1)
    // and carry from (i-1,j).
    for (genvar i = 0; i < WIDTH; i++) begin : g_row
        for (genvar j = 0; j < WIDTH; j++) begin : g_col
            logic s_in, c_in, s_out, c_out;
            if (i == 0) begin : g_top
                assign s_in = 1'b0;
                assign c_in = 1'b0;
            end else if (j == WIDTH-1) begin : g_edge
                assign s_in = 1'b0;
                assign c_in = g_row[i-1].g_col[j].c_out;
            end else begin : g_mid
                assign s_in = g_row[i-1].g_col[j+1].s_out;
                assign c_in = g_row[i-1].g_col[j].c_out;
            end
            narrow_array_mult_cell u_cell (
                .a_bit    (a_g[j]),
                .b_bit    (b_g[i]),
                .sum_in   (s_in),
                .carry_in (c_in),
                .sum_out  (s_out),
                .carry_out(c_out)
            );
        end
    end

    // Tap the column-0 sums and the residual carry-save pairs of the last
    // full row and of the last corner row (row HALF-1).
    for (genvar k = 0; k < WIDTH; k++) begin : g_tap
        assign col0_sum[k]   = g_row[k].g_col[0].s_out;
        assign last_carry[k] = g_row[WIDTH-1].g_col[k].c_out;
        if (k < WIDTH-1) begin : g_ls
            assign last_sum[k] = g_row[WIDTH-1].g_col[k+1].s_out;
        end else begin : g_ls0
            assign last_sum[k] = 1'b0;
        end
        if (k < HALF) begin : g_corner
            assign corner_carry[k] = g_row[HALF-1].g_col[k].c_out;
            if (k < HALF-1) begin : g_cs
                assign corner_sum[k] = g_row[HALF-1].g_col[k+1].s_out;
            end else begin : g_cs0
                assign corner_sum[k] = 1'b0;
            end
        end
    end

    // Final ripple-carry rows; the carry out of the top bit is always zero.
    always_comb begin
        logic rc, cc;
        rc          = 1'b0;
        cc          = 1'b0;
        full_prod   = '0;
        corner_prod = '0;
        full_prod[WIDTH-1:0]  = col0_sum;
        corner_prod[HALF-1:0] = col0_sum[HALF-1:0];
        for (int j = 0; j < WIDTH; j++) begin
            full_prod[WIDTH+j] = last_sum[j] ^ last_carry[j] ^ rc;
            rc = (last_sum[j] & last_carry[j]) | (rc & (last_sum[j] ^ last_carry[j]));
        end
        for (int j = 0; j < HALF; j++) begin
            corner_prod[HALF+j] = corner_sum[j] ^ corner_carry[j] ^ cc;
            cc = (corner_sum[j] & corner_carry[j]) | (cc & (corner_sum[j] ^ corner_carry[j]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            product_q <= '0;
            narrow_q  <= 1'b0;
        end else begin
            product_q <= narrow_d ? {{(PWIDTH-2*HALF){1'b0}}, corner_prod} : full_prod;
            narrow_q  <= narrow_d;
        end
    end

    assign bus.product = product_q;
    assign bus.narrow  = narrow_q;
endmodule

// File: tb/tb_narrow_array_multiplier.sv
// Directed-table, sweep and random-with-reset checks of narrow_array_multiplier at WIDTH=32.
module tb_narrow_array_multiplier;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp_p;
        logic           exp_n;
        string          name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    narrow_array_multiplier_if #(.WIDTH(W)) bus ();

    narrow_array_multiplier #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] exp_p, input logic exp_n);
        n_checks++;
        if (bus.product !== exp_p || bus.narrow !== exp_n) begin
            n_fail++;
            $display("FAIL %s: product=%h narrow=%b expected product=%h narrow=%b",
                     name, bus.product, bus.narrow, exp_p, exp_n);
        end
    endtask

    // Drive operands before an edge, then look at the registered result just after it.
    task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
        bus.a = a;
        bus.b = b;
        rst   = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic ref_narrow(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a[W-1:W/2] == '0) && (b[W-1:W/2] == '0);
    endfunction

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, "max"};
        vecs[1] = '{32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 1'b1, "narrow_edge"};
        vecs[2] = '{32'h0001_0000, 32'h0000_FFFF, 64'h0000_0000_FFFF_0000, 1'b0, "a_just_wide"};
        vecs[3] = '{32'h0000_FFFF, 32'h0001_0000, 64'h0000_0000_FFFF_0000, 1'b0, "b_just_wide"};
        vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 64'h0,                   1'b0, "zero_by_wide"};
        vecs[5] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 1'b0, "asym_msb"};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 64'h0,                   1'b1, "zero_zero"};
        vecs[7] = '{32'h0000_8000, 32'h0000_8000, 64'h0000_0000_4000_0000, 1'b1, "half_msb"};
        vecs[8] = '{32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, 1'b0, "shift4"};
        vecs[9] = '{32'h0000_0001, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b0, "one_by_max"};

        // Reset holds outputs at zero regardless of operands, then releases into a load.
        step(32'd7, 32'd9, 1'b1);
        check("reset_c1", 64'd0, 1'b0);
        step(32'd7, 32'd9, 1'b1);
        check("reset_c2", 64'd0, 1'b0);
        step(32'd7, 32'd9, 1'b0);
        check("reset_release", 64'd63, 1'b1);

        foreach (vecs[i]) begin
            step(vecs[i].a, vecs[i].b, 1'b0);
            check(vecs[i].name, vecs[i].exp_p, vecs[i].exp_n);
        end

        for (int a = 1; a <= 32; a++) begin
            for (int b = 1; b <= 32; b++) begin
                step(W'(a), W'(b), 1'b0);
                check("sweep", 64'(a * b), 1'b1);
            end
        end

        // Back-to-back random pairs with a single-cycle reset in the middle.
        for (int k = 0; k < 10000; k++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (($urandom & 3) == 0) begin
                ra = ra & 32'h0000_FFFF;
                rb = rb & 32'h0000_FFFF;
            end
            if (k == 5000) begin
                step(ra, rb, 1'b1);
                check("midstream_reset", 64'd0, 1'b0);
            end else begin
                step(ra, rb, 1'b0);
                check(k == 5001 ? "after_reset" : "random",
                      64'(ra) * 64'(rb), ref_narrow(ra, rb));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
